seven_seg_scanner: RTL and testbench

Time-multiplexed driver for a 4-digit common-anode seven-segment display. Consumes four BCD digits (one per bcd counter stage of the up/down counter chain) and scans them onto shared segment lines, one digit per refresh slot. Provides leading-zero blanking, per-digit decimal points and a global blank. Sits directly downstream of the BCD counter chain and drives the board's anode/segment pins.

---
 rtl/seven_seg_scanner.sv | 149 ++++++++++++++
 tb/tb_seven_seg_scanner.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed driver for a 4-digit common-anode
// seven-segment display. A free-running divider picks one digit per refresh
// slot; that digit's decoded segments, its decimal point and its anode are
// registered onto the shared pins. Supports leading-zero blanking, per-digit
// decimal points and a global blank that leaves the scan running.

// Per-digit lane: BCD decode plus the leading-zero blank decision for one
// digit position. Only positions above the units digit may be blanked.
module seven_seg_digit #(
    parameter bit ALLOW_BLANK = 1'b1
) (
    input  logic [3:0] num,
    input  logic       above_zero,   // every more-significant digit is zero
    input  logic       blank_lz,
    output logic [6:0] seg_code,     // active-low {g,f,e,d,c,b,a}
    output logic       lz_blank
);

    // Active-low segment decode; non-BCD codes show a dash (segment g only)
    always_comb begin
        seg_code = 7'h3F;
        case (num)
            4'd0:    seg_code = 7'h40;
            4'd1:    seg_code = 7'h79;
            4'd2:    seg_code = 7'h24;
            4'd3:    seg_code = 7'h30;
            4'd4:    seg_code = 7'h19;
            4'd5:    seg_code = 7'h12;
            4'd6:    seg_code = 7'h02;
            4'd7:    seg_code = 7'h78;
            4'd8:    seg_code = 7'h00;
            4'd9:    seg_code = 7'h10;
            default: seg_code = 7'h3F;
        endcase
    end

    // A digit is a leading zero when it and everything to its left are zero
    always_comb begin
        lz_blank = ALLOW_BLANK && blank_lz && above_zero && (num == 4'd0);
    end

endmodule

module seven_seg_scanner #(
    parameter int REFRESH_BITS = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] num3,
    input  logic [3:0] num2,
    input  logic [3:0] num1,
    input  logic [3:0] num0,
    input  logic [3:0] dp_en,
    input  logic       blank_lz,
    input  logic       en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int NUM_DIGITS = 4;

    logic [REFRESH_BITS-1:0]          div_q, div_d;
    logic [1:0]                       idx_q, idx_d;
    logic [3:0]                       an_q, an_d;
    logic [6:0]                       seg_q, seg_d;
    logic                             dp_q, dp_d;

    logic [NUM_DIGITS-1:0][3:0]       nums;
    logic [NUM_DIGITS-1:0]            lane_zero;
    logic [NUM_DIGITS-1:0]            above_zero;
    logic [NUM_DIGITS-1:0][6:0]       lane_seg;
    logic [NUM_DIGITS-1:0]            lane_blank;

    assign nums = {num3, num2, num1, num0};

    // Per-digit zero flags feeding the leading-zero chain
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            lane_zero[i] = (nums[i] == 4'd0);
        end
    end

    // above_zero[i]: all digits left of position i are zero (none for digit3)
    always_comb begin
        above_zero = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            for (int j = i + 1; j < NUM_DIGITS; j++) begin
                if (!lane_zero[j]) above_zero[i] = 1'b0;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_lane
            seven_seg_digit #(
                .ALLOW_BLANK (g != 0)
            ) u_digit (
                .num        (nums[g]),
                .above_zero (above_zero[g]),
                .blank_lz   (blank_lz),
                .seg_code   (lane_seg[g]),
                .lz_blank   (lane_blank[g])
            );
        end
    endgenerate

    // Divider free-runs; digit index steps on the last clock of each slot
    always_comb begin
        div_d = div_q + 1'b1;
        idx_d = idx_q;
        if (div_q == {REFRESH_BITS{1'b1}}) idx_d = idx_q + 2'd1;
    end

    // Next pin state for the digit currently selected; en only darkens
    always_comb begin
        an_d  = 4'b1111;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (en && !lane_blank[idx_q]) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = lane_seg[idx_q];
            dp_d  = ~dp_en[idx_q];
        end
    end

    // All state registered; reset forces display dark and scan back to digit0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
            idx_q <= 2'd0;
            an_q  <= 4'b1111;
            seg_q <= 7'h7F;
            dp_q  <= 1'b1;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner with a 4-clock slot. The stimulus
// process sets inputs between edges and queues the pin state expected after
// the next edge; the monitor pops and compares just after every edge.
module tb_seven_seg_scanner;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] num3 = 4'd0, num2 = 4'd0, num1 = 4'd0, num0 = 4'd0;
    logic [3:0] dp_en = 4'd0;
    logic       blank_lz = 1'b0;
    logic       en = 1'b1;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int vectors = 0;
    int errors  = 0;

    // Expected pin word {an, seg, dp}
    logic [11:0] exp_q[$];

    // Bench-side scan position
    int m_div = 0;
    int m_idx = 0;

    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    seven_seg_scanner #(.REFRESH_BITS(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .num3     (num3),
        .num2     (num2),
        .num1     (num1),
        .num0     (num0),
        .dp_en    (dp_en),
        .blank_lz (blank_lz),
        .en       (en),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] expv);
        vectors++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got an=%b seg=%h dp=%b, want an=%b seg=%h dp=%b",
                     nm, act[11:8], act[7:1], act[0], expv[11:8], expv[7:1], expv[0]);
        end
    endtask

    function automatic logic [11:0] model(input int idx);
        logic [3:0] d;
        logic       blank;
        d = (idx == 0) ? num0 : (idx == 1) ? num1 : (idx == 2) ? num2 : num3;
        blank = !en;
        if (blank_lz) begin
            if (idx == 3 && num3 == 0) blank = 1'b1;
            if (idx == 2 && num3 == 0 && num2 == 0) blank = 1'b1;
            if (idx == 1 && num3 == 0 && num2 == 0 && num1 == 0) blank = 1'b1;
        end
        if (blank) return {4'b1111, 7'h7F, 1'b1};
        return {~(4'b0001 << idx), tbl[d], ~dp_en[idx]};
    endfunction

    // One clock: queue the expectation, take the edge, advance the model
    task automatic step();
        exp_q.push_back(model(m_idx));
        @(posedge clk);
        if (m_div == 3) m_idx = (m_idx + 1) % 4;
        m_div = (m_div + 1) % 4;
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic goto_slot(input int s);
        for (int i = 0; i < 8 && m_idx != s; i++) step();
    endtask

    // Monitor: compare the DUT pins against the oldest queued expectation
    always @(posedge clk) begin
        logic [11:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pins", {an, seg, dp}, e);
            vectors++;
            if ($countones(~an) > 1) begin
                errors++;
                $display("FAIL onehot: got an=%b, want at most one low", an);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_state", {an, seg, dp}, {4'b1111, 7'h7F, 1'b1});
        reset = 1'b0;
        m_div = 0; m_idx = 0;

        // Scan order: digit0 first, 4 clocks per slot, then repeats
        num3 = 4'd1; num2 = 4'd2; num1 = 4'd3; num0 = 4'd4;
        exp_q.push_back({4'b1110, 7'h19, 1'b1});
        @(posedge clk); m_div = 1;
        @(negedge clk);
        steps(19);

        // Live update during slot1
        goto_slot(1);
        step();
        num1 = 4'd9;
        steps(3);

        // Full decode sweep on digit0
        num3 = 4'd8; num2 = 4'd8; num1 = 4'd8;
        for (int v = 0; v < 16; v++) begin
            num0 = 4'(v);
            goto_slot(0);
            step();
        end

        // Leading-zero blanking
        num3 = 4'd0; num2 = 4'd0; num1 = 4'd0; num0 = 4'd7;
        blank_lz = 1'b1;
        steps(16);
        blank_lz = 1'b0;
        steps(16);
        num0 = 4'd0;
        blank_lz = 1'b1;
        steps(16);

        // Decimal point on digit2 only
        blank_lz = 1'b0;
        num3 = 4'd5; num2 = 4'd6; num1 = 4'd7; num0 = 4'd8;
        dp_en = 4'b0100;
        steps(16);

        // Global enable mid-slot; scan keeps counting underneath
        goto_slot(1);
        step();
        en = 1'b0;
        steps(10);
        en = 1'b1;
        steps(12);

        // Async reset mid-slot2, then slot0 gets a full slot first
        goto_slot(2);
        step();
        #2 reset = 1'b1;
        #1 chk("async_reset", {an, seg, dp}, {4'b1111, 7'h7F, 1'b1});
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_div = 0; m_idx = 0;
        steps(8);

        @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
